// File: rtl/neuron_sequencer.sv
// neuron_sequencer: one neuron evaluation on a shared signed MAC datapath.
// Optional build macro NEURON_SEQ_RELU_EN rectifies negative results to zero.
module neuron_sequencer #(
    parameter int N_INPUTS   = 4,
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 20,
    parameter int FRAC_SHIFT = 8,
    parameter int CNT_W      = $clog2(N_INPUTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] weight,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y,
    output logic              sat,
    output logic              busy,
    output logic [CNT_W-1:0]  beat_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        BIAS,
        OUT
    } state_t;

    localparam logic signed [ACC_W-1:0] YMAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] YMIN = ACC_W'(-(2 ** (DATA_W - 1)));
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]        bias_q, bias_d;
    logic [DATA_W-1:0]        y_q, y_d;
    logic                     sat_q, sat_d;
    logic                     out_valid_q, out_valid_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    acc_b;
    logic signed [ACC_W-1:0]    r;

    // datapath terms: full-width product, biased sum and rescaled result
    always_comb begin
        prod     = $signed(x) * $signed(weight);
        prod_ext = {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
        bias_ext = {{(ACC_W - DATA_W){bias_q[DATA_W-1]}}, bias_q};
        acc_b    = acc_q + (bias_ext <<< FRAC_SHIFT);
        r        = acc_b >>> FRAC_SHIFT;
`ifdef NEURON_SEQ_RELU_EN
        if (r < 0) begin
            r = '0;
        end
`endif
    end

    // next-state and datapath update; abort overrides every state
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bias_d  = bias_q;
        y_d     = y_q;
        sat_d   = sat_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bias_d  = bias;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_d = BIAS;
                    end
                end
            end
            BIAS: begin
                acc_d = acc_b;
                if (r > YMAX) begin
                    y_d   = YMAX[DATA_W-1:0];
                    sat_d = 1'b1;
                end else if (r < YMIN) begin
                    y_d   = YMIN[DATA_W-1:0];
                    sat_d = 1'b1;
                end else begin
                    y_d   = r[DATA_W-1:0];
                    sat_d = 1'b0;
                end
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
        out_valid_d = (state_d == OUT);
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            bias_q      <= '0;
            y_q         <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bias_q      <= bias_d;
            y_q         <= y_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign sat       = sat_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// tb_neuron_sequencer: directed and random evaluations against
// an arithmetic reference model of the neuron result.
module tb_neuron_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] bias = '0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] x = '0;
    logic [7:0] weight = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] y;
    logic       sat;
    logic       busy;
    logic [2:0] beat_cnt;

    int total = 0;
    int bad = 0;
    int xs[N];
    int ws[N];

    neuron_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .weight(weight), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .sat(sat), .busy(busy),
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // neuron result from the arithmetic rules: floor-divided sum, clamp
    task automatic model(input int b, output int ey, output int es);
        int s;
        int r;
        s = b * 256;
        for (int i = 0; i < N; i++) s += xs[i] * ws[i];
        r = (s - (((s % 256) + 256) % 256)) / 256;
`ifdef NEURON_SEQ_RELU_EN
        if (r < 0) r = 0;
`endif
        es = 0;
        ey = r;
        if (r > 127) begin ey = 127; es = 1; end
        if (r < -128) begin ey = -128; es = 1; end
    endtask

    task automatic set_all(input int xv, input int wv);
        for (int i = 0; i < N; i++) begin
            xs[i] = xv;
            ws[i] = wv;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_beat_cnt"}, 32'(beat_cnt), 0);
        check({tag, "_y"}, 32'(y), 0);
        check({tag, "_sat"}, 32'(sat), 0);
    endtask

    // start, stream pairs with optional gaps, wait for out_valid, check result
    task automatic feed(input string tag, input int b, input int gap,
                        input bit chk_lat);
        int edges;
        int ey;
        int es;
        model(b, ey, es);
        start = 1'b1;
        bias = 8'(b);
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 1);
        edges = 0;
        for (int i = 0; i < N; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    start = 1'b1;
                    tick();
                    edges++;
                end
                start = 1'b0;
            end
            in_valid = 1'b1;
            x = 8'(xs[i]);
            weight = 8'(ws[i]);
            if (in_ready !== 1'b1) check({tag, "_in_ready"}, 32'(in_ready), 1);
            tick();
            edges++;
        end
        in_valid = 1'b0;
        check({tag, "_bias_no_valid"}, 32'(out_valid), 0);
        for (int k = 0; k < 20 && out_valid !== 1'b1; k++) begin
            tick();
            edges++;
        end
        check({tag, "_out_valid"}, 32'(out_valid), 1);
        if (chk_lat) check({tag, "_latency"}, edges, N + 1);
        check({tag, "_y"}, $signed(y), ey);
        check({tag, "_sat"}, 32'(sat), es);
        check({tag, "_beat_cnt"}, 32'(beat_cnt), N);
    endtask

    // hold off the consumer, then accept; start is ignored throughout
    task automatic drain(input string tag, input int stall);
        logic [7:0] y0;
        logic s0;
        y0 = y;
        s0 = sat;
        for (int k = 0; k < stall; k++) begin
            start = 1'b1;
            tick();
            check({tag, "_hold_valid"}, 32'(out_valid), 1);
            check({tag, "_hold_y"}, 32'(y), 32'(y0));
            check({tag, "_hold_sat"}, 32'(sat), 32'(s0));
        end
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 32'(out_valid), 0);
        check({tag, "_idle"}, 32'(busy), 0);
        tick();
        check({tag, "_no_restart"}, 32'(busy), 0);
    endtask

    initial begin
        int rb;
        #2;
        check_reset("reset");
        #10;
        rst = 1'b1;
        tick();

        set_all(64, 64);
        feed("basic", 0, 0, 1);
        drain("basic", 0);

        set_all(127, 127);
        feed("satpos", 0, 0, 1);
        drain("satpos", 1);

        set_all(-128, 127);
        feed("satneg", 0, 0, 0);
        drain("satneg", 0);

        set_all(0, 0);
        feed("bias5", 5, 0, 0);
        drain("bias5", 0);

        set_all(1, 1);
        feed("biasneg", -3, 0, 0);
        drain("biasneg", 0);

        set_all(64, 64);
        feed("stall", 0, 2, 0);
        drain("stall", 3);

        start = 1'b1;
        bias = 8'd0;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        x = 8'd100;
        weight = 8'd100;
        tick();
        tick();
        in_valid = 1'b0;
        check("abort_cnt", 32'(beat_cnt), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(out_valid), 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid !== 1'b0) check("abort_spurious", 32'(out_valid), 0);
        end
        set_all(64, 64);
        feed("after_abort", 0, 0, 1);
        drain("after_abort", 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        x = 8'd50;
        weight = 8'd90;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_reset("rst_accum");
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        tick();
        set_all(64, 64);
        feed("after_rst1", 0, 0, 1);
        #2;
        rst = 1'b0;
        #1;
        check_reset("rst_out");
        #3;
        rst = 1'b1;
        tick();
        set_all(-7, 33);
        feed("after_rst2", 20, 0, 1);
        drain("after_rst2", 0);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) begin
                xs[i] = int'($urandom_range(255)) - 128;
                ws[i] = int'($urandom_range(255)) - 128;
            end
            rb = int'($urandom_range(255)) - 128;
            feed("rand", rb, int'($urandom_range(2)), 0);
            drain("rand", int'($urandom_range(3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
